// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes used by fetch and control,
// the canonical NOP word, and the fetch FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_S_TYPE = 7'b0100011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_L_TYPE = 7'b0000011;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OUT   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/opcode_legal_chk.sv
// Flags an opcode outside the supported base set; only meaningful while
// an instruction is being presented.
module opcode_legal_chk
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       valid,
    output logic       illegal
);

    logic known;

    always_comb begin
        known = 1'b0;
        case (opcode)
            OP_R_TYPE, OP_S_TYPE, OP_I_TYPE, OP_L_TYPE,
            OP_B_TYPE, OP_JAL, OP_JALR: known = 1'b1;
            default:                    known = 1'b0;
        endcase
    end

    assign illegal = valid & ~known;

endmodule

// File: rtl/instr_fetch.sv
// Non-prefetching instruction fetch front-end: one outstanding memory
// request, presents the fetched word to decode, honours PC redirects.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(riscv_pkg::NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_t    state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] instr_reg;
    logic [XLEN-1:0] pc_out_reg;
    logic            drop_reg;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    // drop_reg marks an outstanding response that a redirect has made stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            drop_reg   <= 1'b0;
            instr_reg  <= NOP_INSTR;
            pc_out_reg <= RESET_PC;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (redirect_en) pc_reg <= redirect_tgt;
                    if (imem_ready) begin
                        state_reg <= WAIT;
                        drop_reg  <= redirect_en;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_reg || redirect_en) begin
                            drop_reg  <= 1'b0;
                            state_reg <= FETCH;
                            if (redirect_en) pc_reg <= redirect_tgt;
                        end else begin
                            instr_reg  <= imem_rdata;
                            pc_out_reg <= pc_reg;
                            state_reg  <= OUT;
                        end
                    end else if (redirect_en) begin
                        pc_reg   <= redirect_tgt;
                        drop_reg <= 1'b1;
                    end
                end
                OUT: begin
                    if (redirect_en) begin
                        pc_reg    <= redirect_tgt;
                        state_reg <= FETCH;
                    end else if (instr_ready) begin
                        pc_reg    <= pc_reg + XLEN'(4);
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign imem_req    = (state_reg == FETCH) && !rst;
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == OUT);
    assign instr       = instr_reg;
    assign opcode      = instr_reg[6:0];
    assign pc_out      = pc_out_reg;

    opcode_legal_chk u_legal (
        .opcode  (opcode),
        .valid   (instr_valid),
        .illegal (illegal)
    );

endmodule
